gshare_bht: RTL and testbench
=============================

# gshare_bht

Parametrised gshare branch history table for the frontend; successor to the per-PC 2-bit BHT. Row index = PC bits XOR a speculative global history register (GHR). Counter width, history length and fetch width are configurable. Features beyond the per-PC BHT:
- in-block GHR with mispredict recovery
- multi-cycle flush/reset sweep FSM (RAM-friendly, no single-cycle bulk clear)
- `ready_o` status

## Interface
- NR_ENTRIES, 1024: total counters; power of two.
- INSTR_PER_FETCH, 2: predictions per fetch (slots per row); power of two.
- CTR_BITS, 2: saturating counter width, ≥2.
- GHR_BITS, 8: history length; 1 ≤ GHR_BITS ≤ ROW_BITS.
- VLEN, 39: virtual PC width.
- OFFSET, 1: PC LSBs ignored (1 with RVC, 2 without).
- Derived:
  - NR_ROWS = NR_ENTRIES/INSTR_PER_FETCH
  - ROW_BITS = $clog2(NR_ROWS)
  - SLOT_BITS = max(1, $clog2(INSTR_PER_FETCH))
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  invalidate table (starts sweep).
- debug_mode_i  in  1  suppresses all history pushes and table updates.
- vpc_i  in  VLEN  fetch PC.
- spec_valid_i  in  1  frontend predicted a conditional branch this cycle; push into GHR.
- spec_taken_i  in  1  predicted direction to push.
- upd_valid_i  in  1  resolved conditional branch.
- upd_pc_i  in  VLEN  PC of resolved branch.
- upd_taken_i  in  1  resolved direction.
- upd_ghr_i  in  GHR_BITS  GHR snapshot that was used when this branch was predicted.
- upd_mispredict_i  in  1  resolved direction differs from prediction; repair GHR.
- pred_valid_o  out  INSTR_PER_FETCH  per-slot entry valid.
- pred_taken_o  out  INSTR_PER_FETCH  per-slot counter MSB.
- ghr_o  out  GHR_BITS  current GHR (frontend snapshots it alongside the branch).
- ready_o  out  1  table usable; 0 during sweep.

## Operation
- Storage: NR_ROWS × INSTR_PER_FETCH entries of {valid, ctr[CTR_BITS-1:0]}.
- Lookup:
  - row = vpc_i[ROW_BITS+SLOT_BITS+OFFSET-1 : SLOT_BITS+OFFSET] XOR zero-extended ghr_q.
  - All slots of the row are output.
- Update:
  - urow = upd_pc_i row bits XOR zero-extended upd_ghr_i.
  - uslot = upd_pc_i[SLOT_BITS+OFFSET-1:OFFSET]; uslot = 0 when INSTR_PER_FETCH = 1.
  - Entry valid ← 1.
  - ctr += 1 if taken, saturating at 2^CTR_BITS−1; ctr −= 1 if not taken, saturating at 0.
  - Applied only when upd_valid_i && !debug_mode_i && state = IDLE.
- GHR, evaluated in priority order each cycle (debug_mode_i=1 blocks all three):
  1. upd_valid_i && upd_mispredict_i: ghr_q ← {upd_ghr_i[GHR_BITS-2:0], upd_taken_i}. Any same-cycle spec push is discarded.
  2. Else spec_valid_i: ghr_q ← {ghr_q[GHR_BITS-2:0], spec_taken_i}.
  3. Else hold.
  - For GHR_BITS=1 the shift degenerates to the new bit alone.
- GHR updates are independent of the table's state and operate during SWEEP.
- FSM states: SWEEP, IDLE.
  - SWEEP: each cycle writes row sweep_q, all slots, to {valid=0, ctr=2^(CTR_BITS-1)} (weakly taken). sweep_q increments.
  - SWEEP → IDLE after writing row NR_ROWS−1.
  - IDLE → SWEEP (sweep_q ← 0) on flush_i.
  - flush_i during SWEEP restarts the sweep at row 0.
  - Updates arriving during SWEEP are dropped, not queued.
- While in SWEEP: ready_o=0, pred_valid_o=0, pred_taken_o=0.

## Timing
- Reset values:
  - state = SWEEP, sweep_q = 0, ghr_q = 0.
  - ready_o = 0, pred_valid_o = 0, pred_taken_o = 0, ghr_o = 0.
  - Table contents are undefined until the sweep completes.
- Sweep length: NR_ROWS cycles after rst_ni deassertion or after the flush_i cycle. ready_o rises on cycle NR_ROWS.
- Prediction: combinational from vpc_i and ghr_q, zero cycles.
- Table write: visible to lookups the cycle after the update.
- Same-cycle update and lookup of the same entry: lookup returns the old value. No bypass.
- GHR change: visible on ghr_o and in indexing the next cycle.
- Reset asserted mid-operation: immediate asynchronous return to the reset values above; a full sweep follows.

## Test plan
- Reset, NR_ENTRIES=1024, IPF=2:
  - ready_o=0 for exactly 512 cycles after reset release, then 1.
  - Any lookup then gives valid=0, taken=1.
- Saturation, CTR_BITS=3:
  - 5 taken updates to PC 0x100 with upd_ghr_i=0 → ctr=7; taken=1.
  - Then 8 not-taken → ctr=0; taken=0; valid stays 1.
- Hash separation:
  - Update PC 0x100 taken ×2 with upd_ghr_i=0x00; update PC 0x100 not-taken ×2 with upd_ghr_i=0x01.
  - Lookup with ghr=0 → taken=1; with ghr=1 → taken=0.
- GHR recovery:
  - spec pushes 1,1,0 from ghr=0 → ghr_o=0x06.
  - Mispredict with upd_ghr_i=0x03, taken=0, plus a simultaneous spec push → ghr_o=0x06 (recovered value; spec push discarded).
- Flush mid-sweep and drop rule:
  - flush_i at sweep row 100 → ready_o stays 0 for a further 512 cycles.
  - An update issued during the sweep has no effect once IDLE.
- Debug mode, debug_mode_i=1:
  - upd_valid_i and spec_valid_i change neither counters nor ghr_o.
  - Deasserting debug_mode_i restores normal updates.

Source files
------------

// File: rtl/gshare_bht.sv
// -----------------------------------------------------------------------------
// gshare_bht
//
// Gshare branch history table. Each table row holds INSTR_PER_FETCH entries
// of {valid, saturating counter}. The row used for a lookup is selected by the
// fetch PC row bits XOR-ed with a speculative global history register (GHR)
// that lives inside this block. Resolved branches train the row that was
// selected when they were predicted: the frontend hands the GHR snapshot back
// on upd_ghr_i.
//
// The table is cleared by a multi-cycle sweep (one row per cycle) after
// reset and after every flush. No single-cycle bulk clear exists, so the
// storage can be mapped to RAM.
//
// Handshake: there is no backpressure. spec_valid_i and upd_valid_i are
// single-cycle strobes that are consumed on the clock edge where they are
// high. Updates that arrive while the table is sweeping (ready_o = 0) or while
// debug_mode_i = 1 are dropped, not queued.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              restart the clearing sweep at row 0
//   debug_mode_i         blocks all GHR pushes and all table updates
//   vpc_i                fetch PC used for the combinational lookup
//   spec_valid_i/taken_i speculative direction pushed into the GHR
//   upd_valid_i          resolved conditional branch
//   upd_pc_i/taken_i     its PC and resolved direction
//   upd_ghr_i            GHR snapshot used when the branch was predicted
//   upd_mispredict_i     repair the GHR from upd_ghr_i and upd_taken_i
//   pred_valid_o         per-slot entry valid for the looked-up row
//   pred_taken_o         per-slot counter MSB for the looked-up row
//   ghr_o                current GHR
//   ready_o              table usable (low during the sweep)
// -----------------------------------------------------------------------------
module gshare_bht #(
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned CTR_BITS        = 2,
  parameter int unsigned GHR_BITS        = 8,
  parameter int unsigned VLEN            = 39,
  parameter int unsigned OFFSET          = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       spec_valid_i,
  input  logic                       spec_taken_i,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic                       upd_taken_i,
  input  logic [GHR_BITS-1:0]        upd_ghr_i,
  input  logic                       upd_mispredict_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  output logic [GHR_BITS-1:0]        ghr_o,
  output logic                       ready_o
);

  localparam int unsigned NR_ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_BITS  = $clog2(NR_ROWS);
  localparam int unsigned SLOT_BITS = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
  localparam int unsigned ROW_LSB   = SLOT_BITS + OFFSET;

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  // Weakly taken: MSB set, all other bits clear.
  localparam logic [CTR_BITS-1:0] CTR_WEAK = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(NR_ROWS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ROW_BITS-1:0] sweep_q, sweep_d;
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  // Table storage. Not reset: the sweep defines every entry before use.
  logic                valid_q [NR_ROWS][INSTR_PER_FETCH];
  logic [CTR_BITS-1:0] ctr_q   [NR_ROWS][INSTR_PER_FETCH];

  // Shift a new outcome into a history value. Written as shift-and-or so it
  // stays legal when GHR_BITS = 1 (result is then just the new bit).
  function automatic logic [GHR_BITS-1:0] push_hist(input logic [GHR_BITS-1:0] hist,
                                                    input logic                bit_in);
    return (hist << 1) | GHR_BITS'(bit_in);
  endfunction

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  logic [ROW_BITS-1:0] lkp_row;

  assign lkp_row = vpc_i[ROW_LSB +: ROW_BITS] ^ ROW_BITS'(ghr_q);

  always_comb begin
    pred_valid_o = '0;
    pred_taken_o = '0;
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      pred_valid_o[s] = (state_q == IDLE) & valid_q[lkp_row][s];
      pred_taken_o[s] = (state_q == IDLE) & ctr_q[lkp_row][s][CTR_BITS-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------------
  logic [ROW_BITS-1:0]  upd_row;
  logic [SLOT_BITS-1:0] upd_slot;
  logic                 upd_en;
  logic [CTR_BITS-1:0]  upd_ctr_old;
  logic [CTR_BITS-1:0]  upd_ctr_new;

  assign upd_row = upd_pc_i[ROW_LSB +: ROW_BITS] ^ ROW_BITS'(upd_ghr_i);

  generate
    if (INSTR_PER_FETCH > 1) begin : g_slot
      assign upd_slot = upd_pc_i[OFFSET +: SLOT_BITS];
    end else begin : g_one_slot
      assign upd_slot = '0;
    end
  endgenerate

  assign upd_en      = upd_valid_i & ~debug_mode_i & (state_q == IDLE);
  assign upd_ctr_old = ctr_q[upd_row][upd_slot];

  always_comb begin
    upd_ctr_new = upd_ctr_old;
    if (upd_taken_i) begin
      if (upd_ctr_old != CTR_MAX) upd_ctr_new = upd_ctr_old + CTR_BITS'(1);
    end else begin
      if (upd_ctr_old != '0) upd_ctr_new = upd_ctr_old - CTR_BITS'(1);
    end
  end

  // Single write port: the sweep owns it while active, otherwise one entry
  // may be trained per cycle.
  always_ff @(posedge clk_i) begin
    if (state_q == SWEEP) begin
      for (int s = 0; s < INSTR_PER_FETCH; s++) begin
        valid_q[sweep_q][s] <= 1'b0;
        ctr_q[sweep_q][s]   <= CTR_WEAK;
      end
    end else if (upd_en) begin
      valid_q[upd_row][upd_slot] <= 1'b1;
      ctr_q[upd_row][upd_slot]   <= upd_ctr_new;
    end
  end

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      SWEEP: begin
        sweep_d = sweep_q + ROW_BITS'(1);
        if (sweep_q == LAST_ROW) state_d = IDLE;
      end
      IDLE: begin
        sweep_d = sweep_q;
      end
      default: begin
        state_d = SWEEP;
        sweep_d = '0;
      end
    endcase
    // A flush always (re)starts the sweep from row 0, even mid-sweep.
    if (flush_i) begin
      state_d = SWEEP;
      sweep_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Global history. Runs regardless of the sweep; a mispredict repair wins
  // over a same-cycle speculative push.
  // ---------------------------------------------------------------------------
  always_comb begin
    ghr_d = ghr_q;
    if (!debug_mode_i) begin
      if (upd_valid_i && upd_mispredict_i) begin
        ghr_d = push_hist(upd_ghr_i, upd_taken_i);
      end else if (spec_valid_i) begin
        ghr_d = push_hist(ghr_q, spec_taken_i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SWEEP;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q   <= ghr_d;
    end
  end

  assign ghr_o   = ghr_q;
  assign ready_o = (state_q == IDLE);

  // PC bits outside the row/slot fields do not take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{vpc_i, upd_pc_i};

endmodule

// File: tb/tb_gshare_bht.sv
// -----------------------------------------------------------------------------
// tb_gshare_bht: directed bench for gshare_bht with NR_ENTRIES=1024,
// INSTR_PER_FETCH=2, CTR_BITS=3, GHR_BITS=8, OFFSET=1.
// Row of a PC = pc[10:2] ^ ghr, slot = pc[1]. PC 0x100 -> row 64, slot 0.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_gshare_bht;

  localparam int unsigned NR_ENTRIES = 1024;
  localparam int unsigned IPF        = 2;
  localparam int unsigned CTR_BITS   = 3;
  localparam int unsigned GHR_BITS   = 8;
  localparam int unsigned VLEN       = 39;
  localparam int unsigned OFFSET     = 1;
  localparam int          NR_ROWS    = 512;

  logic                clk_i;
  logic                rst_ni;
  logic                flush_i;
  logic                debug_mode_i;
  logic [VLEN-1:0]     vpc_i;
  logic                spec_valid_i;
  logic                spec_taken_i;
  logic                upd_valid_i;
  logic [VLEN-1:0]     upd_pc_i;
  logic                upd_taken_i;
  logic [GHR_BITS-1:0] upd_ghr_i;
  logic                upd_mispredict_i;
  logic [IPF-1:0]      pred_valid_o;
  logic [IPF-1:0]      pred_taken_o;
  logic [GHR_BITS-1:0] ghr_o;
  logic                ready_o;

  int checks   = 0;
  int failures = 0;

  gshare_bht #(
    .NR_ENTRIES     (NR_ENTRIES),
    .INSTR_PER_FETCH(IPF),
    .CTR_BITS       (CTR_BITS),
    .GHR_BITS       (GHR_BITS),
    .VLEN           (VLEN),
    .OFFSET         (OFFSET)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .debug_mode_i    (debug_mode_i),
    .vpc_i           (vpc_i),
    .spec_valid_i    (spec_valid_i),
    .spec_taken_i    (spec_taken_i),
    .upd_valid_i     (upd_valid_i),
    .upd_pc_i        (upd_pc_i),
    .upd_taken_i     (upd_taken_i),
    .upd_ghr_i       (upd_ghr_i),
    .upd_mispredict_i(upd_mispredict_i),
    .pred_valid_o    (pred_valid_o),
    .pred_taken_o    (pred_taken_o),
    .ghr_o           (ghr_o),
    .ready_o         (ready_o)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_update(input logic [VLEN-1:0] pc, input logic taken,
                           input logic [GHR_BITS-1:0] hist, input logic mispred);
    upd_valid_i      = 1'b1;
    upd_pc_i         = pc;
    upd_taken_i      = taken;
    upd_ghr_i        = hist;
    upd_mispredict_i = mispred;
    next_cycle();
    upd_valid_i      = 1'b0;
    upd_mispredict_i = 1'b0;
  endtask

  task automatic spec_push(input logic taken);
    spec_valid_i = 1'b1;
    spec_taken_i = taken;
    next_cycle();
    spec_valid_i = 1'b0;
  endtask

  task automatic set_ghr(input logic [GHR_BITS-1:0] value);
    for (int i = GHR_BITS - 1; i >= 0; i--) spec_push(value[i]);
  endtask

  task automatic flush_cycle();
    flush_i = 1'b1;
    next_cycle();
    flush_i = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_o && n < 2000) begin
      next_cycle();
      n++;
    end
  endtask

  task automatic lookup(input logic [VLEN-1:0] pc);
    vpc_i = pc;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int n;
    rst_ni = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    checks++; if (pred_valid_o !== 2'b00) begin failures++; $display("FAIL reset_pvalid: got %b want 00", pred_valid_o); end
    checks++; if (pred_taken_o !== 2'b00) begin failures++; $display("FAIL reset_ptaken: got %b want 00", pred_taken_o); end
    checks++; if (ghr_o !== 8'h00) begin failures++; $display("FAIL reset_ghr: got %h want 00", ghr_o); end
    repeat (2) next_cycle();
    rst_ni = 1'b1;
    vpc_i  = '0;
    n = 0;
    while (!ready_o && n < 2000) begin
      next_cycle();
      n++;
      if (n == 10) begin
        // Row 0 is already swept here, so its counter MSB would be 1 ungated.
        checks++; if (pred_taken_o !== 2'b00) begin failures++; $display("FAIL sweep_ptaken: got %b want 00", pred_taken_o); end
        checks++; if (pred_valid_o !== 2'b00) begin failures++; $display("FAIL sweep_pvalid: got %b want 00", pred_valid_o); end
      end
    end
    checks++; if (n !== NR_ROWS) begin failures++; $display("FAIL reset_sweep_len: got %0d want %0d", n, NR_ROWS); end
    lookup(39'h100);
    checks++; if (pred_valid_o !== 2'b00) begin failures++; $display("FAIL init_valid: got %b want 00", pred_valid_o); end
    checks++; if (pred_taken_o !== 2'b11) begin failures++; $display("FAIL init_taken: got %b want 11", pred_taken_o); end
    lookup(39'h7FE);
    checks++; if ({pred_valid_o, pred_taken_o} !== 4'b0011) begin failures++; $display("FAIL init_hi_row: got %b want 0011", {pred_valid_o, pred_taken_o}); end
  endtask

  // Counter starts at 4 (weakly taken, CTR_BITS=3).
  task automatic test_saturation();
    repeat (5) do_update(39'h100, 1'b1, 8'h00, 1'b0);        // 4 -> 7
    lookup(39'h100);
    checks++; if (pred_valid_o !== 2'b01) begin failures++; $display("FAIL sat_valid: got %b want 01", pred_valid_o); end
    checks++; if (pred_taken_o !== 2'b11) begin failures++; $display("FAIL sat_hi_taken: got %b want 11", pred_taken_o); end
    repeat (3) do_update(39'h100, 1'b0, 8'h00, 1'b0);        // 7 -> 4
    lookup(39'h100);
    checks++; if (pred_taken_o !== 2'b11) begin failures++; $display("FAIL sat_hi_held: got %b want 11", pred_taken_o); end
    repeat (5) do_update(39'h100, 1'b0, 8'h00, 1'b0);        // 4 -> 0
    lookup(39'h100);
    checks++; if (pred_taken_o !== 2'b10) begin failures++; $display("FAIL sat_lo_taken: got %b want 10", pred_taken_o); end
    checks++; if (pred_valid_o !== 2'b01) begin failures++; $display("FAIL sat_lo_valid: got %b want 01", pred_valid_o); end
    repeat (3) do_update(39'h100, 1'b1, 8'h00, 1'b0);        // 0 -> 3
    lookup(39'h100);
    checks++; if (pred_taken_o !== 2'b10) begin failures++; $display("FAIL sat_lo_held: got %b want 10", pred_taken_o); end
    do_update(39'h100, 1'b1, 8'h00, 1'b0);                   // 3 -> 4
    lookup(39'h100);
    checks++; if (pred_taken_o !== 2'b11) begin failures++; $display("FAIL sat_recross: got %b want 11", pred_taken_o); end
  endtask

  task automatic test_hash();
    int n;
    flush_cycle();
    wait_ready(n);
    checks++; if (n !== NR_ROWS) begin failures++; $display("FAIL flush_sweep_len: got %0d want %0d", n, NR_ROWS); end
    repeat (2) do_update(39'h100, 1'b1, 8'h00, 1'b0);        // row 64: 4 -> 6
    repeat (2) do_update(39'h100, 1'b0, 8'h01, 1'b0);        // row 65: 4 -> 2
    lookup(39'h100);
    checks++; if ({pred_valid_o, pred_taken_o} !== 4'b0111) begin failures++; $display("FAIL hash_ghr0: got %b want 0111", {pred_valid_o, pred_taken_o}); end
    spec_push(1'b1);
    checks++; if (ghr_o !== 8'h01) begin failures++; $display("FAIL hash_ghr_push: got %h want 01", ghr_o); end
    lookup(39'h100);
    checks++; if ({pred_valid_o, pred_taken_o} !== 4'b0110) begin failures++; $display("FAIL hash_ghr1: got %b want 0110", {pred_valid_o, pred_taken_o}); end
    lookup(39'h104);                                         // 65 ^ 1 = row 64
    checks++; if ({pred_valid_o, pred_taken_o} !== 4'b0111) begin failures++; $display("FAIL hash_alias: got %b want 0111", {pred_valid_o, pred_taken_o}); end
  endtask

  task automatic test_ghr_recovery();
    set_ghr(8'h00);
    checks++; if (ghr_o !== 8'h00) begin failures++; $display("FAIL ghr_clear: got %h want 00", ghr_o); end
    spec_push(1'b1);
    spec_push(1'b1);
    spec_push(1'b0);
    checks++; if (ghr_o !== 8'h06) begin failures++; $display("FAIL ghr_spec: got %h want 06", ghr_o); end
    // Mispredict repair with a simultaneous spec push of 1 (would give 0x0D).
    spec_valid_i = 1'b1;
    spec_taken_i = 1'b1;
    do_update(39'h0, 1'b0, 8'h03, 1'b1);
    spec_valid_i = 1'b0;
    checks++; if (ghr_o !== 8'h06) begin failures++; $display("FAIL ghr_recover: got %h want 06", ghr_o); end
    do_update(39'h0, 1'b1, 8'h55, 1'b1);
    checks++; if (ghr_o !== 8'hAB) begin failures++; $display("FAIL ghr_recover2: got %h want ab", ghr_o); end
    do_update(39'h0, 1'b1, 8'h55, 1'b0);                     // no mispredict: hold
    checks++; if (ghr_o !== 8'hAB) begin failures++; $display("FAIL ghr_hold: got %h want ab", ghr_o); end
    spec_push(1'b0);
    checks++; if (ghr_o !== 8'h56) begin failures++; $display("FAIL ghr_shift_out: got %h want 56", ghr_o); end
  endtask

  task automatic test_flush_mid_sweep();
    int n;
    set_ghr(8'h00);
    flush_cycle();
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        spec_push(1'b1);                                     // GHR keeps working in SWEEP
        checks++; if (ghr_o !== 8'h01) begin failures++; $display("FAIL sweep_ghr: got %h want 01", ghr_o); end
      end else begin
        next_cycle();
      end
    end
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL sweep_row100_ready: got %b want 0", ready_o); end
    flush_cycle();
    // Reset the GHR during the sweep so the dropped update targets row 128.
    set_ghr(8'h00);
    n = GHR_BITS;
    while (!ready_o && n < 2000) begin
      upd_valid_i = (n >= 300 && n < 303);
      upd_pc_i    = 39'h200;
      upd_taken_i = 1'b1;
      upd_ghr_i   = 8'h00;
      next_cycle();
      n++;
    end
    upd_valid_i = 1'b0;
    checks++; if (n !== NR_ROWS) begin failures++; $display("FAIL restart_sweep_len: got %0d want %0d", n, NR_ROWS); end
    lookup(39'h200);
    checks++; if ({pred_valid_o, pred_taken_o} !== 4'b0011) begin failures++; $display("FAIL sweep_drop: got %b want 0011", {pred_valid_o, pred_taken_o}); end
    lookup(39'h100);
    checks++; if ({pred_valid_o, pred_taken_o} !== 4'b0011) begin failures++; $display("FAIL flush_clears: got %b want 0011", {pred_valid_o, pred_taken_o}); end
  endtask

  task automatic test_debug();
    debug_mode_i = 1'b1;
    spec_valid_i = 1'b1;
    spec_taken_i = 1'b1;
    repeat (3) do_update(39'h100, 1'b0, 8'h10, 1'b1);
    repeat (3) do_update(39'h100, 1'b0, 8'h00, 1'b0);
    spec_valid_i = 1'b0;
    checks++; if (ghr_o !== 8'h00) begin failures++; $display("FAIL dbg_ghr: got %h want 00", ghr_o); end
    lookup(39'h100);
    checks++; if ({pred_valid_o, pred_taken_o} !== 4'b0011) begin failures++; $display("FAIL dbg_table: got %b want 0011", {pred_valid_o, pred_taken_o}); end
    debug_mode_i = 1'b0;
    do_update(39'h100, 1'b0, 8'h00, 1'b0);                   // 4 -> 3
    lookup(39'h100);
    checks++; if ({pred_valid_o, pred_taken_o} !== 4'b0110) begin failures++; $display("FAIL dbg_exit_table: got %b want 0110", {pred_valid_o, pred_taken_o}); end
    spec_push(1'b1);
    checks++; if (ghr_o !== 8'h01) begin failures++; $display("FAIL dbg_exit_ghr: got %h want 01", ghr_o); end
    set_ghr(8'h00);
  endtask

  // Same-cycle update and lookup: old value until the edge, new value after.
  task automatic test_back_to_back();
    vpc_i            = 39'h100;
    upd_valid_i      = 1'b1;
    upd_pc_i         = 39'h100;
    upd_taken_i      = 1'b1;
    upd_ghr_i        = 8'h00;
    upd_mispredict_i = 1'b0;
    #1;
    checks++; if (pred_taken_o !== 2'b10) begin failures++; $display("FAIL no_bypass: got %b want 10", pred_taken_o); end
    next_cycle();                                            // 3 -> 4
    checks++; if (pred_taken_o !== 2'b11) begin failures++; $display("FAIL b2b_first: got %b want 11", pred_taken_o); end
    upd_taken_i = 1'b0;
    next_cycle();                                            // 4 -> 3
    upd_valid_i = 1'b0;
    checks++; if (pred_taken_o !== 2'b10) begin failures++; $display("FAIL b2b_second: got %b want 10", pred_taken_o); end
  endtask

  task automatic test_reset_midop();
    int n;
    spec_push(1'b1);
    spec_push(1'b0);
    checks++; if (ghr_o !== 8'h02) begin failures++; $display("FAIL midrst_pre_ghr: got %h want 02", ghr_o); end
    #1;
    rst_ni = 1'b0;
    #1;
    checks++; if ({ready_o, ghr_o} !== 9'h000) begin failures++; $display("FAIL midrst_async: got %h want 000", {ready_o, ghr_o}); end
    next_cycle();
    rst_ni = 1'b1;
    wait_ready(n);
    checks++; if (n !== NR_ROWS) begin failures++; $display("FAIL midrst_sweep_len: got %0d want %0d", n, NR_ROWS); end
    lookup(39'h100);
    checks++; if ({pred_valid_o, pred_taken_o} !== 4'b0011) begin failures++; $display("FAIL midrst_table: got %b want 0011", {pred_valid_o, pred_taken_o}); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    flush_i          = 1'b0;
    debug_mode_i     = 1'b0;
    vpc_i            = '0;
    spec_valid_i     = 1'b0;
    spec_taken_i     = 1'b0;
    upd_valid_i      = 1'b0;
    upd_pc_i         = '0;
    upd_taken_i      = 1'b0;
    upd_ghr_i        = '0;
    upd_mispredict_i = 1'b0;
    rst_ni           = 1'b1;

    test_reset();
    test_saturation();
    test_hash();
    test_ghr_recovery();
    test_flush_mid_sweep();
    test_debug();
    test_back_to_back();
    test_reset_midop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
